// File: rtl/avst_pkg.sv
// avst_pkg: shared FSM state type, byte width and the empty-field width
// helper used by the Avalon-ST byte serializer and its interfaces.
package avst_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    SERIAL = 1'b1
  } serState_t;

  // empty carries one extra bit so that out-of-range values (>= N) can be
  // represented and handled rather than silently wrapping
  function automatic int emptyWidth(input int nBytes);
    return $clog2(nBytes) + 1;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// avalon_st_if: Avalon-ST style packet beat bundle, DATA_WIDTH_IN_BYTES
// byte symbols per beat with big-endian symbol order and a byte empty count.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 4
);
  localparam int DATA_W  = DATA_WIDTH_IN_BYTES * avst_pkg::BYTE_W;
  localparam int EMPTY_W = avst_pkg::emptyWidth(DATA_WIDTH_IN_BYTES);

  logic [DATA_W-1:0]  data;
  logic [EMPTY_W-1:0] empty;
  logic               sop;
  logic               eop;
  logic               vld;
  logic               rdy;

  modport master (output data, empty, sop, eop, vld, input rdy);
  modport slave  (input data, empty, sop, eop, vld, output rdy);
endinterface

// File: rtl/dvr_if.sv
// dvr_if: plain data/valid/ready transfer bundle.
interface dvr_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  vld;
  logic                  rdy;

  modport master (output data, vld, input rdy);
  modport slave  (input data, vld, output rdy);
endinterface

// File: rtl/avst_byte_serializer.sv
// avst_byte_serializer: breaks each accepted Avalon-ST beat into single
// bytes, most-significant byte first, marking packet start/end per byte.
// A new beat is accepted in the same cycle the last byte of the held beat
// leaves, so back-to-back beats stream without a bubble.
// Optional macro AVST_BYTE_SERIALIZER_ERR_EN adds a sticky 'err' output
// flagging framing violations and impossible empty counts.
module avst_byte_serializer
  import avst_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  avalon_st_if.slave in_if,
  dvr_if.master      out_if,
  output logic       out_sop,
  output logic       out_eop
`ifdef AVST_BYTE_SERIALIZER_ERR_EN
  ,
  output logic       err
`endif
);

  localparam int N       = DATA_WIDTH_IN_BYTES;
  localparam int DATA_W  = N * BYTE_W;
  localparam int EMPTY_W = emptyWidth(N);
  localparam int IDX_W   = $clog2(N);
  localparam int CNT_W   = IDX_W + 1;

  serState_t          r_state;
  serState_t          w_nextState;
  logic [DATA_W-1:0]  r_data;
  logic [EMPTY_W-1:0] r_empty;
  logic               r_sop;
  logic               r_eop;
  logic [IDX_W-1:0]   r_idx;

  logic [CNT_W-1:0]   w_byteCount;
  logic               w_lastByte;
  logic               w_inRdy;
  logic               w_outVld;
  logic               w_outSop;
  logic               w_outEop;
  logic [BYTE_W-1:0]  w_outData;
  logic               w_inXfer;
  logic               w_outXfer;

  // Number of valid bytes in the held beat; an empty count that would leave
  // nothing is clamped so the beat still produces its single eop byte.
  always_comb begin
    w_byteCount = CNT_W'(N);
    if (r_eop) begin
      if (r_empty >= EMPTY_W'(N)) begin
        w_byteCount = CNT_W'(1);
      end else begin
        w_byteCount = CNT_W'(N) - CNT_W'(r_empty);
      end
    end
  end

  assign w_lastByte = ({1'b0, r_idx} == (w_byteCount - CNT_W'(1)));

  // Select the current byte from the held beat, index 0 being the MSB.
  always_comb begin
    w_outData = '0;
    for (int k = 0; k < N; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_outData = r_data[DATA_W-1-BYTE_W*k -: BYTE_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next-state: leave SERIAL only when the last byte goes with no refill.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_inXfer) begin
          w_nextState = SERIAL;
        end
      end
      SERIAL: begin
        if (w_outXfer && w_lastByte) begin
          w_nextState = w_inXfer ? SERIAL : IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs: input ready opens only when idle or as the final byte leaves.
  always_comb begin
    w_inRdy  = 1'b0;
    w_outVld = 1'b0;
    w_outSop = 1'b0;
    w_outEop = 1'b0;
    case (r_state)
      IDLE: begin
        w_inRdy = !rst;
      end
      SERIAL: begin
        w_outVld = 1'b1;
        w_inRdy  = !rst && out_if.rdy && w_lastByte;
        w_outSop = r_sop && (r_idx == '0);
        w_outEop = r_eop && w_lastByte;
      end
      default: ;
    endcase
  end

  assign w_inXfer  = in_if.vld && w_inRdy;
  assign w_outXfer = w_outVld && out_if.rdy;

  assign in_if.rdy   = w_inRdy;
  assign out_if.vld  = w_outVld;
  assign out_if.data = w_outData;
  assign out_sop     = w_outSop;
  assign out_eop     = w_outEop;

  // Held beat and byte index: load on input transfer, advance on output transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_empty <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_idx   <= '0;
    end else if (w_inXfer) begin
      r_data  <= in_if.data;
      r_empty <= in_if.empty;
      r_sop   <= in_if.sop;
      r_eop   <= in_if.eop;
      r_idx   <= '0;
    end else if (w_outXfer) begin
      r_idx   <= r_idx + IDX_W'(1);
    end
  end

`ifdef AVST_BYTE_SERIALIZER_ERR_EN
  logic r_inPacket;
  logic r_err;
  logic w_protoViolation;

  assign w_protoViolation = (in_if.sop && r_inPacket) ||
                            (!in_if.sop && !r_inPacket) ||
                            (in_if.eop && (in_if.empty >= EMPTY_W'(N)));

  // Track packet framing across accepted beats and latch any violation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inPacket <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_inXfer) begin
      r_inPacket <= !in_if.eop;
      if (w_protoViolation) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_avst_byte_serializer.sv
// tb_avst_byte_serializer: randomized self-checking bench for the byte
// serializer at N=4, comparing against a byte-list reference model.
`timescale 1ns/1ps
module tb_avst_byte_serializer;

  localparam int N       = 4;
  localparam int TIMEOUT = 200;

  typedef struct {
    logic [7:0] b;
    logic       sop;
    logic       eop;
    logic       last;
  } obyte_t;

  typedef struct {
    logic       rst;
    logic       inVld;
    logic       inRdy;
    logic       vld;
    logic       outRdy;
    logic       sop;
    logic       eop;
    logic [7:0] data;
    logic       err;
  } sample_t;

  logic clk;
  logic rst;
  logic outSop;
  logic outEop;
`ifdef AVST_BYTE_SERIALIZER_ERR_EN
  logic err;
`endif

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(N)) inIf ();
  dvr_if #(.DATA_WIDTH(8)) outIf ();

  int checks  = 0;
  int errors  = 0;
  int rdyMode = 0;

  obyte_t  expQ[$];
  obyte_t  gotQ[$];
  sample_t trace[$];

  avst_byte_serializer #(.DATA_WIDTH_IN_BYTES(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .in_if  (inIf),
    .out_if (outIf),
    .out_sop(outSop),
    .out_eop(outEop)
`ifdef AVST_BYTE_SERIALIZER_ERR_EN
    ,
    .err    (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a beat becomes its valid bytes, MSB first.
  function automatic void modelBeat(input logic [31:0] d, input logic sop,
                                    input logic eop, input int empty);
    int cnt;
    cnt = !eop ? N : ((empty >= N) ? 1 : N - empty);
    for (int k = 0; k < cnt; k++) begin
      obyte_t o;
      o.b    = d[8*(N-1-k) +: 8];
      o.sop  = sop && (k == 0);
      o.eop  = eop && (k == cnt - 1);
      o.last = (k == cnt - 1);
      expQ.push_back(o);
    end
  endfunction

  task automatic resetQueues();
    expQ.delete();
    gotQ.delete();
    trace.delete();
  endtask

  // One cycle: set out ready, sample mid-cycle, then advance to next negedge.
  task automatic tick();
    sample_t s;
    case (rdyMode)
      0:       outIf.rdy = 1'b1;
      1:       outIf.rdy = ~outIf.rdy;
      2:       outIf.rdy = 1'($urandom_range(0, 1));
      default: outIf.rdy = 1'b0;
    endcase
    #1;
    s.rst    = rst;
    s.inVld  = inIf.vld;
    s.inRdy  = inIf.rdy;
    s.vld    = outIf.vld;
    s.outRdy = outIf.rdy;
    s.sop    = outSop;
    s.eop    = outEop;
    s.data   = outIf.data;
`ifdef AVST_BYTE_SERIALIZER_ERR_EN
    s.err    = err;
`else
    s.err    = 1'b0;
`endif
    trace.push_back(s);
    if (!s.rst && s.vld === 1'b1 && s.outRdy === 1'b1) begin
      obyte_t o;
      o.b    = s.data;
      o.sop  = s.sop;
      o.eop  = s.eop;
      o.last = 1'b0;
      gotQ.push_back(o);
    end
    @(negedge clk);
  endtask

  task automatic sendBeat(input logic [31:0] d, input logic sop,
                          input logic eop, input logic [2:0] empty);
    bit done;
    done      = 0;
    inIf.vld  = 1'b1;
    inIf.data = d;
    inIf.sop  = sop;
    inIf.eop  = eop;
    inIf.empty = empty;
    modelBeat(d, sop, eop, int'(empty));
    for (int i = 0; i < TIMEOUT && !done; i++) begin
      tick();
      if (trace[$].inRdy === 1'b1) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL beat_accept: in rdy never seen, required within %0d cycles", TIMEOUT);
    end
    inIf.vld = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      if (gotQ.size() >= expQ.size() && trace[$].vld === 1'b0) break;
    end
  endtask

  task automatic test_reset();
    resetQueues();
    rdyMode  = 0;
    rst      = 1'b1;
    inIf.vld = 1'b1;
    inIf.data = $urandom;
    inIf.sop = 1'b1;
    inIf.eop = 1'b1;
    inIf.empty = 3'd0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (trace[i].inRdy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_in_rdy: got %b required 0 (cycle %0d)", trace[i].inRdy, i);
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if ({trace[i].vld, trace[i].sop, trace[i].eop} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got vld/sop/eop %b%b%b required 000",
                 trace[i].vld, trace[i].sop, trace[i].eop);
      end
    end
    rst      = 1'b0;
    inIf.vld = 1'b0;
    tick();
    checks++;
    if (trace[3].inRdy !== 1'b1 || trace[3].vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got in_rdy %b vld %b required 1 0",
               trace[3].inRdy, trace[3].vld);
    end
  endtask

  task automatic test_single_beat();
    int t0;
    resetQueues();
    rdyMode = 0;
    sendBeat(32'hA1B2C3D4, 1'b1, 1'b1, 3'd0);
    t0 = trace.size() - 1;
    repeat (5) tick();
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (trace[t0+k].vld !== 1'b1 || trace[t0+k].data !== expQ[k-1].b ||
          trace[t0+k].sop !== (k == 1) || trace[t0+k].eop !== (k == 4)) begin
        errors++;
        $display("[TB] FAIL single_byte%0d: got vld %b data %h sop %b eop %b required 1 %h %b %b",
                 k, trace[t0+k].vld, trace[t0+k].data, trace[t0+k].sop, trace[t0+k].eop,
                 expQ[k-1].b, (k == 1), (k == 4));
      end
    end
    checks++;
    if (trace[t0+4].inRdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_last_in_rdy: got %b required 1", trace[t0+4].inRdy);
    end
    checks++;
    if (trace[t0+5].vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle_after: got vld %b required 0", trace[t0+5].vld);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    resetQueues();
    rdyMode = 0;
    sendBeat($urandom, 1'b1, 1'b0, 3'd0);
    t0 = trace.size() - 1;
    sendBeat($urandom, 1'b0, 1'b1, 3'd2);
    repeat (3) tick();
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (trace[t0+k].vld !== 1'b1 || trace[t0+k].data !== expQ[k-1].b ||
          trace[t0+k].sop !== expQ[k-1].sop || trace[t0+k].eop !== expQ[k-1].eop) begin
        errors++;
        $display("[TB] FAIL b2b_byte%0d: got vld %b data %h sop %b eop %b required 1 %h %b %b",
                 k, trace[t0+k].vld, trace[t0+k].data, trace[t0+k].sop, trace[t0+k].eop,
                 expQ[k-1].b, expQ[k-1].sop, expQ[k-1].eop);
      end
    end
    checks++;
    if (trace[t0+7].vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle_after: got vld %b required 0", trace[t0+7].vld);
    end
  endtask

  task automatic test_toggle_rdy();
    int gotIdx;
    resetQueues();
    rdyMode = 1;
    sendBeat($urandom, 1'b1, 1'b0, 3'd0);
    sendBeat($urandom, 1'b0, 1'b0, 3'd0);
    sendBeat($urandom, 1'b0, 1'b1, 3'($urandom_range(0, 3)));
    drain();
    gotIdx = 0;
    foreach (trace[i]) begin
      if (trace[i].vld === 1'b1 && gotIdx < expQ.size()) begin
        checks++;
        if (trace[i].data !== expQ[gotIdx].b || trace[i].sop !== expQ[gotIdx].sop ||
            trace[i].eop !== expQ[gotIdx].eop ||
            trace[i].inRdy !== (trace[i].outRdy && expQ[gotIdx].last)) begin
          errors++;
          $display("[TB] FAIL toggle_byte%0d: got data %h sop %b eop %b in_rdy %b required %h %b %b %b",
                   gotIdx, trace[i].data, trace[i].sop, trace[i].eop, trace[i].inRdy,
                   expQ[gotIdx].b, expQ[gotIdx].sop, expQ[gotIdx].eop,
                   trace[i].outRdy && expQ[gotIdx].last);
        end
        if (trace[i].outRdy === 1'b1) gotIdx++;
      end
    end
    checks++;
    if (gotIdx != expQ.size()) begin
      errors++;
      $display("[TB] FAIL toggle_count: got %0d bytes required %0d", gotIdx, expQ.size());
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    resetQueues();
    rdyMode = 0;
    sendBeat($urandom, 1'b1, 1'b1, 3'd0);
    t0 = trace.size() - 1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(expQ.pop_back());
    void'(expQ.pop_back());
    tick();
    checks++;
    if (trace[t0+3].inRdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_in_rdy: got %b required 0", trace[t0+3].inRdy);
    end
    checks++;
    if (trace[t0+4].vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_vld: got %b required 0", trace[t0+4].vld);
    end
    sendBeat($urandom, 1'b1, 1'b1, 3'd1);
    drain();
    checks++;
    if (gotQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL rstmid_count: got %0d bytes required %0d", gotQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      checks++;
      if ({gotQ[i].b, gotQ[i].sop, gotQ[i].eop} !== {expQ[i].b, expQ[i].sop, expQ[i].eop}) begin
        errors++;
        $display("[TB] FAIL rstmid_byte%0d: got %h/%b/%b required %h/%b/%b", i,
                 gotQ[i].b, gotQ[i].sop, gotQ[i].eop, expQ[i].b, expQ[i].sop, expQ[i].eop);
      end
    end
  endtask

  task automatic test_empty_clamp();
    resetQueues();
    rdyMode = 0;
    sendBeat($urandom, 1'b1, 1'b1, 3'd5);
    sendBeat($urandom, 1'b1, 1'b1, 3'd4);
    drain();
    checks++;
    if (gotQ.size() != 2) begin
      errors++;
      $display("[TB] FAIL clamp_count: got %0d bytes required 2", gotQ.size());
    end
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      checks++;
      if ({gotQ[i].b, gotQ[i].sop, gotQ[i].eop} !== {expQ[i].b, expQ[i].sop, expQ[i].eop}) begin
        errors++;
        $display("[TB] FAIL clamp_byte%0d: got %h/%b/%b required %h/%b/%b", i,
                 gotQ[i].b, gotQ[i].sop, gotQ[i].eop, expQ[i].b, expQ[i].sop, expQ[i].eop);
      end
    end
  endtask

  task automatic test_random();
    int gotIdx;
    int beats;
    resetQueues();
    rdyMode = 2;
    for (int p = 0; p < 8; p++) begin
      beats = $urandom_range(1, 3);
      for (int b = 0; b < beats; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        sendBeat($urandom, (b == 0), (b == beats - 1),
                 (b == beats - 1) ? 3'($urandom_range(0, 3)) : 3'd0);
      end
    end
    drain();
    gotIdx = 0;
    foreach (trace[i]) begin
      if (trace[i].vld === 1'b1 && gotIdx < expQ.size()) begin
        checks++;
        if (trace[i].data !== expQ[gotIdx].b || trace[i].sop !== expQ[gotIdx].sop ||
            trace[i].eop !== expQ[gotIdx].eop ||
            trace[i].inRdy !== (trace[i].outRdy && expQ[gotIdx].last)) begin
          errors++;
          $display("[TB] FAIL random_byte%0d: got data %h sop %b eop %b in_rdy %b required %h %b %b %b",
                   gotIdx, trace[i].data, trace[i].sop, trace[i].eop, trace[i].inRdy,
                   expQ[gotIdx].b, expQ[gotIdx].sop, expQ[gotIdx].eop,
                   trace[i].outRdy && expQ[gotIdx].last);
        end
        if (trace[i].outRdy === 1'b1) gotIdx++;
      end
    end
    checks++;
    if (gotIdx != expQ.size()) begin
      errors++;
      $display("[TB] FAIL random_count: got %0d bytes required %0d", gotIdx, expQ.size());
    end
  endtask

`ifdef AVST_BYTE_SERIALIZER_ERR_EN
  task automatic test_err();
    resetQueues();
    rdyMode = 0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (trace[$].err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_after_reset: got %b required 0", trace[$].err);
    end
    resetQueues();
    sendBeat($urandom, 1'b0, 1'b1, 3'd0);
    tick();
    checks++;
    if (trace[$].err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_set: got %b required 1", trace[$].err);
    end
    drain();
    repeat (3) tick();
    checks++;
    if (trace[$].err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_sticky: got %b required 1", trace[$].err);
    end
    checks++;
    if (gotQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL err_bytes: got %0d bytes required %0d", gotQ.size(), expQ.size());
    end
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checks++;
    if (trace[$].err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear: got %b required 0", trace[$].err);
    end
  endtask
`endif

  // Global time bound so a stuck handshake can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    rst        = 1'b1;
    inIf.vld   = 1'b0;
    inIf.data  = '0;
    inIf.sop   = 1'b0;
    inIf.eop   = 1'b0;
    inIf.empty = '0;
    outIf.rdy  = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_toggle_rdy();
    test_reset_mid();
    test_empty_clamp();
    test_random();
`ifdef AVST_BYTE_SERIALIZER_ERR_EN
    test_err();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
